// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage: 2-entry skid FIFO between fetch and decode with synchronous flush.
// Optional idle-cycle counter on bubble_count when IF_ID_BUBBLE_COUNT_EN is defined.
module if_id_skid_stage #(
  parameter int unsigned        INSTR_W  = 32,
  parameter int unsigned        PC_W     = 32,
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(32'h0000_0000)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc4,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc4,
  output logic [5:0]         out_opcode,
  output logic [5:0]         out_funct,
  output logic               out_is_rtype
`ifdef IF_ID_BUBBLE_COUNT_EN
  ,
  output logic [15:0]        bubble_count
`endif
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned BUB_W = 16;

  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [PC_W-1:0]    r_pc4   [DEPTH];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_is_rtype;

  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_wr_ptr_nxt;
  logic               w_rd_ptr_nxt;
  logic [5:0]         w_head_opcode_nxt;
  logic               w_is_rtype_nxt;

  // Handshakes and next pointer/count; flush overrides push and pop.
  always_comb begin
    w_push       = in_valid & in_ready;
    w_pop        = out_valid & out_ready;
    w_count_nxt  = r_count;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (flush) begin
      w_count_nxt  = '0;
      w_wr_ptr_nxt = 1'b0;
      w_rd_ptr_nxt = 1'b0;
    end else begin
      if (w_push && !w_pop) begin
        w_count_nxt = r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        w_count_nxt = r_count - CNT_W'(1);
      end
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + 1'b1;
      end
    end
  end

  // Next head opcode: the incoming word when it lands in the next head slot.
  always_comb begin
    w_head_opcode_nxt = r_instr[w_rd_ptr_nxt][31:26];
    if (w_push && !flush && (w_rd_ptr_nxt == r_wr_ptr)) begin
      w_head_opcode_nxt = in_instr[31:26];
    end
    w_is_rtype_nxt = (w_count_nxt != '0) && (w_head_opcode_nxt == 6'b000000);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_is_rtype <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_is_rtype <= w_is_rtype_nxt;
    end
  end

  // Entry storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clock) begin
    if (w_push && !flush) begin
      r_instr[r_wr_ptr] <= in_instr;
      r_pc4[r_wr_ptr]   <= in_pc4;
    end
  end

  always_comb begin
    in_ready     = (r_count != CNT_W'(DEPTH));
    out_valid    = (r_count != '0);
    out_instr    = out_valid ? r_instr[r_rd_ptr] : NOP_WORD;
    out_pc4      = out_valid ? r_pc4[r_rd_ptr] : '0;
    out_opcode   = out_instr[31:26];
    out_funct    = out_instr[5:0];
    out_is_rtype = r_is_rtype;
  end

`ifdef IF_ID_BUBBLE_COUNT_EN
  logic [BUB_W-1:0] r_bubble_count;

  // Saturating count of cycles with nothing presented to decode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bubble_count <= '0;
    end else if (!out_valid && (r_bubble_count != {BUB_W{1'b1}})) begin
      r_bubble_count <= r_bubble_count + BUB_W'(1);
    end
  end

  assign bubble_count = r_bubble_count;
`endif

endmodule
